// File: rtl/lane_striper_n.sv
// lane_striper_n: double-banked TX striper and RX de-striper across NUM_LANES lanes.
// Ordered sets bypass the banks through a 1-deep register stage on each path.
module lane_striper_n #(
   parameter int NUM_LANES = 2,
   parameter int W         = 8,
   parameter int CHUNK     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable_t,
   input  logic                   enable_r,
   input  logic                   data_os,
   input  logic                   tx_in_valid,
   output logic                   tx_in_ready,
   input  logic [W-1:0]           tx_in_data,
   input  logic [NUM_LANES*W-1:0] tx_os_data,
   output logic                   tx_out_valid,
   input  logic                   tx_out_ready,
   output logic [NUM_LANES*W-1:0] tx_out_data,
   input  logic                   rx_in_valid,
   output logic                   rx_in_ready,
   input  logic [NUM_LANES*W-1:0] rx_in_data,
   output logic                   rx_out_valid,
   input  logic                   rx_out_ready,
   output logic [NUM_LANES*W-1:0] rx_out_data,
   output logic                   rx_lanes_on
);
   localparam int B  = NUM_LANES * CHUNK;
   localparam int DW = NUM_LANES * W;
   localparam int CW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic {MODE_OS = 1'b0, MODE_DATA = 1'b1} mode_t;

   mode_t           r_tx_mode;
   logic [W-1:0]    r_tx_bank [2][B];
   logic [1:0]      r_tx_full;
   logic            r_tx_wr, r_tx_rd;
   logic [BW-1:0]   r_tx_wptr;
   logic [CW-1:0]   r_tx_rptr;
   logic            r_tx_os_valid;
   logic [DW-1:0]   r_tx_os_data;
   logic            w_tx_flush, w_tx_idle, w_tx_stall, w_tx_acc, w_tx_done;
   mode_t           w_tx_mode;

   assign w_tx_flush = rst | ~enable_t;
   assign w_tx_idle  = (r_tx_full == 2'b00) && (r_tx_wptr == '0) && !r_tx_os_valid;
   assign w_tx_mode  = w_tx_idle ? mode_t'(data_os) : r_tx_mode;
   // A pending mode change stalls only at a block boundary so a partial block can still complete.
   assign w_tx_stall = (mode_t'(data_os) != w_tx_mode) && (r_tx_wptr == '0);
   assign tx_in_ready = !w_tx_flush && !w_tx_stall &&
                        ((w_tx_mode == MODE_DATA) ? !r_tx_full[r_tx_wr]
                                                  : (!r_tx_os_valid || tx_out_ready));
   assign w_tx_acc     = tx_in_valid && tx_in_ready;
   assign tx_out_valid = (r_tx_mode == MODE_DATA) ? r_tx_full[r_tx_rd] : r_tx_os_valid;
   assign w_tx_done    = (r_tx_mode == MODE_DATA) && tx_out_valid && tx_out_ready;

   always_comb begin
      tx_out_data = '0;
      if (r_tx_mode == MODE_OS) begin
         if (r_tx_os_valid) tx_out_data = r_tx_os_data;
      end else if (r_tx_full[r_tx_rd]) begin
         for (int unsigned l = 0; l < NUM_LANES; l++)
            tx_out_data[l*W +: W] = r_tx_bank[r_tx_rd][BW'(l*CHUNK) + BW'(r_tx_rptr)];
      end
   end

   always_ff @(posedge clk) begin
      if (w_tx_flush) begin
         r_tx_mode     <= MODE_OS;
         r_tx_full     <= '0;
         r_tx_wr       <= 1'b0;
         r_tx_rd       <= 1'b0;
         r_tx_wptr     <= '0;
         r_tx_rptr     <= '0;
         r_tx_os_valid <= 1'b0;
         r_tx_os_data  <= '0;
      end else begin
         if (w_tx_idle) r_tx_mode <= mode_t'(data_os);
         if (w_tx_acc && w_tx_mode == MODE_DATA) begin
            r_tx_bank[r_tx_wr][r_tx_wptr] <= tx_in_data;
            if (r_tx_wptr == BW'(B-1)) begin
               r_tx_full[r_tx_wr] <= 1'b1;
               r_tx_wr            <= ~r_tx_wr;
               r_tx_wptr          <= '0;
            end else begin
               r_tx_wptr <= r_tx_wptr + 1'b1;
            end
         end
         if (w_tx_done) begin
            if (r_tx_rptr == CW'(CHUNK-1)) begin
               r_tx_full[r_tx_rd] <= 1'b0;
               r_tx_rd            <= ~r_tx_rd;
               r_tx_rptr          <= '0;
            end else begin
               r_tx_rptr <= r_tx_rptr + 1'b1;
            end
         end
         if (w_tx_acc && w_tx_mode == MODE_OS) begin
            r_tx_os_valid <= 1'b1;
            r_tx_os_data  <= tx_os_data;
         end else if (tx_out_ready) begin
            r_tx_os_valid <= 1'b0;
         end
      end
   end

   mode_t           r_rx_mode;
   logic [DW-1:0]   r_rx_bank [2][CHUNK];
   logic [1:0]      r_rx_full;
   logic            r_rx_wr, r_rx_rd;
   logic [CW-1:0]   r_rx_wptr;
   logic [BW-1:0]   r_rx_rptr;
   logic            r_rx_os_valid;
   logic [DW-1:0]   r_rx_os_data;
   logic            w_rx_flush, w_rx_idle, w_rx_stall, w_rx_acc, w_rx_done;
   mode_t           w_rx_mode;
   logic [CW-1:0]   w_rx_beat_idx;
   logic [LW-1:0]   w_rx_lane;
   logic [DW-1:0]   w_rx_beat;

   assign rx_lanes_on = enable_r & ~rst;
   assign w_rx_flush  = rst | ~enable_r;
   assign w_rx_idle   = (r_rx_full == 2'b00) && (r_rx_wptr == '0) && !r_rx_os_valid;
   assign w_rx_mode   = w_rx_idle ? mode_t'(data_os) : r_rx_mode;
   assign w_rx_stall  = (mode_t'(data_os) != w_rx_mode) && (r_rx_wptr == '0);
   assign rx_in_ready = !w_rx_flush && !w_rx_stall &&
                        ((w_rx_mode == MODE_DATA) ? !r_rx_full[r_rx_wr]
                                                  : (!r_rx_os_valid || rx_out_ready));
   assign w_rx_acc     = rx_in_valid && rx_in_ready;
   assign rx_out_valid = (r_rx_mode == MODE_DATA) ? r_rx_full[r_rx_rd] : r_rx_os_valid;
   assign w_rx_done    = (r_rx_mode == MODE_DATA) && rx_out_valid && rx_out_ready;

   assign w_rx_beat_idx = CW'(32'(r_rx_rptr) % CHUNK);
   assign w_rx_lane     = LW'(32'(r_rx_rptr) / CHUNK);
   assign w_rx_beat     = r_rx_bank[r_rx_rd][w_rx_beat_idx];

   always_comb begin
      rx_out_data = '0;
      if (r_rx_mode == MODE_OS) begin
         if (r_rx_os_valid) rx_out_data = r_rx_os_data;
      end else if (r_rx_full[r_rx_rd]) begin
         for (int unsigned l = 0; l < NUM_LANES; l++)
            if (w_rx_lane == LW'(l)) rx_out_data[W-1:0] = w_rx_beat[l*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (w_rx_flush) begin
         r_rx_mode     <= MODE_OS;
         r_rx_full     <= '0;
         r_rx_wr       <= 1'b0;
         r_rx_rd       <= 1'b0;
         r_rx_wptr     <= '0;
         r_rx_rptr     <= '0;
         r_rx_os_valid <= 1'b0;
         r_rx_os_data  <= '0;
      end else begin
         if (w_rx_idle) r_rx_mode <= mode_t'(data_os);
         if (w_rx_acc && w_rx_mode == MODE_DATA) begin
            r_rx_bank[r_rx_wr][r_rx_wptr] <= rx_in_data;
            if (r_rx_wptr == CW'(CHUNK-1)) begin
               r_rx_full[r_rx_wr] <= 1'b1;
               r_rx_wr            <= ~r_rx_wr;
               r_rx_wptr          <= '0;
            end else begin
               r_rx_wptr <= r_rx_wptr + 1'b1;
            end
         end
         if (w_rx_done) begin
            if (r_rx_rptr == BW'(B-1)) begin
               r_rx_full[r_rx_rd] <= 1'b0;
               r_rx_rd            <= ~r_rx_rd;
               r_rx_rptr          <= '0;
            end else begin
               r_rx_rptr <= r_rx_rptr + 1'b1;
            end
         end
         if (w_rx_acc && w_rx_mode == MODE_OS) begin
            r_rx_os_valid <= 1'b1;
            r_rx_os_data  <= rx_in_data;
         end else if (rx_out_ready) begin
            r_rx_os_valid <= 1'b0;
         end
      end
   end
endmodule
